// File: rtl/commit_controller_pkg.sv
// Shared types for the in-order commit controller.
// Entry kinds at the ROB head and the controller's FSM states.
package commit_controller_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        CT_REG    = 2'd0,
        CT_STORE  = 2'd1,
        CT_BRANCH = 2'd2,
        CT_HALT   = 2'd3
    } ct_e;

    typedef enum logic [2:0] {
        S_RUN,
        S_ST_WAIT,
        S_ROLLBACK,
        S_FLUSH,
        S_HALT
    } state_e;

endpackage

// File: rtl/commit_controller.sv
// Retires the ROB head in order, one entry per cycle at most.
// Drives the register-file commit port, the store path and rollback.
module commit_controller
    import commit_controller_pkg::*;
#(
    parameter int ROB_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [1:0]           head_type,
    input  logic [REG_W-1:0]     head_dest,
    input  logic [ROB_IDX_W-1:0] head_alias,
    input  logic [DATA_W-1:0]    head_value,
    input  logic                 head_mispredict,
    input  logic [DATA_W-1:0]    head_target_pc,
    output logic                 commit_pop,
    output logic                 rf_result_valid,
    output logic [REG_W-1:0]     rf_reg_id,
    output logic [ROB_IDX_W-1:0] rf_alias,
    output logic [DATA_W-1:0]    rf_result,
    output logic                 store_commit,
    output logic [ROB_IDX_W-1:0] store_alias,
    input  logic                 store_done,
    output logic                 rollback,
    output logic                 redirect_valid,
    output logic [DATA_W-1:0]    redirect_pc,
    output logic                 halted,
    output logic [DATA_W-1:0]    commit_count
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rfv_q, rfv_d;
    logic [REG_W-1:0]       rid_q, rid_d;
    logic [ROB_IDX_W-1:0]   ral_q, ral_d;
    logic [DATA_W-1:0]      res_q, res_d;
    logic                   sc_q, sc_d;
    logic [ROB_IDX_W-1:0]   sal_q, sal_d;
    logic                   rb_q, rb_d;
    logic                   rv_q, rv_d;
    logic [DATA_W-1:0]      pc_q, pc_d;
    logic [DATA_W-1:0]      tgt_q, tgt_d;
    logic                   halt_q, halt_d;
    logic [DATA_W-1:0]      cnt32_q, cnt32_d;
    logic                   pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rfv_d   = 1'b0;
        rid_d   = rid_q;
        ral_d   = ral_q;
        res_d   = res_q;
        sc_d    = 1'b0;
        sal_d   = sal_q;
        rb_d    = 1'b0;
        rv_d    = 1'b0;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        halt_d  = halt_q;
        pop     = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (head_valid && head_ready) begin
                    unique case (ct_e'(head_type))
                        CT_REG, CT_BRANCH: begin
                            pop   = 1'b1;
                            rfv_d = (head_dest != '0);
                            rid_d = head_dest;
                            ral_d = head_alias;
                            res_d = head_value;
                            // Link write goes out one cycle ahead of the flush pulse
                            if (ct_e'(head_type) == CT_BRANCH && head_mispredict) begin
                                tgt_d   = head_target_pc;
                                state_d = S_ROLLBACK;
                            end
                        end
                        CT_STORE: begin
                            sc_d    = 1'b1;
                            sal_d   = head_alias;
                            state_d = S_ST_WAIT;
                        end
                        CT_HALT: begin
                            pop     = 1'b1;
                            halt_d  = 1'b1;
                            state_d = S_HALT;
                        end
                    endcase
                end
            end
            S_ST_WAIT: begin
                pop = store_done;
                if (store_done) state_d = S_RUN;
            end
            S_ROLLBACK: begin
                rb_d    = 1'b1;
                rv_d    = 1'b1;
                pc_d    = tgt_q;
                cnt_d   = CNT_W'(FLUSH_CYCLES);
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HALT: ;
            default: state_d = S_RUN;
        endcase

        cnt32_d = cnt32_q + DATA_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            rfv_q   <= 1'b0;
            rid_q   <= '0;
            ral_q   <= '0;
            res_q   <= '0;
            sc_q    <= 1'b0;
            sal_q   <= '0;
            rb_q    <= 1'b0;
            rv_q    <= 1'b0;
            pc_q    <= '0;
            tgt_q   <= '0;
            halt_q  <= 1'b0;
            cnt32_q <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rfv_q   <= rfv_d;
            rid_q   <= rid_d;
            ral_q   <= ral_d;
            res_q   <= res_d;
            sc_q    <= sc_d;
            sal_q   <= sal_d;
            rb_q    <= rb_d;
            rv_q    <= rv_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            halt_q  <= halt_d;
            cnt32_q <= cnt32_d;
        end
    end

    assign commit_pop      = pop & rdy;
    assign rf_result_valid = rfv_q;
    assign rf_reg_id       = rid_q;
    assign rf_alias        = ral_q;
    assign rf_result       = res_q;
    assign store_commit    = sc_q;
    assign store_alias     = sal_q;
    assign rollback        = rb_q;
    assign redirect_valid  = rv_q;
    assign redirect_pc     = pc_q;
    assign halted          = halt_q;
    assign commit_count    = cnt32_q;

endmodule

// File: tb/tb_commit_controller.sv
// Directed bench for commit_controller: vector table plus
// hand sequences for rdy stall, halt and asynchronous reset.
module tb_commit_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        head_valid = 1'b0;
    logic        head_ready = 1'b0;
    logic [1:0]  head_type = 2'd0;
    logic [4:0]  head_dest = 5'd0;
    logic [3:0]  head_alias = 4'd0;
    logic [31:0] head_value = 32'd0;
    logic        head_mispredict = 1'b0;
    logic [31:0] head_target_pc = 32'd0;
    logic        store_done = 1'b0;

    logic        commit_pop;
    logic        rf_result_valid;
    logic [4:0]  rf_reg_id;
    logic [3:0]  rf_alias;
    logic [31:0] rf_result;
    logic        store_commit;
    logic [3:0]  store_alias;
    logic        rollback;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] commit_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    commit_controller #(.ROB_IDX_W(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .head_valid(head_valid), .head_ready(head_ready),
        .head_type(head_type), .head_dest(head_dest),
        .head_alias(head_alias), .head_value(head_value),
        .head_mispredict(head_mispredict),
        .head_target_pc(head_target_pc),
        .commit_pop(commit_pop),
        .rf_result_valid(rf_result_valid), .rf_reg_id(rf_reg_id),
        .rf_alias(rf_alias), .rf_result(rf_result),
        .store_commit(store_commit), .store_alias(store_alias),
        .store_done(store_done),
        .rollback(rollback), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted),
        .commit_count(commit_count)
    );

    typedef struct {
        logic        hv, hr;
        logic [1:0]  ty;
        logic [4:0]  dst;
        logic [3:0]  al;
        logic [31:0] val;
        logic        mp;
        logic [31:0] tgt;
        logic        sd;
        logic        e_pop, e_rfv;
        logic [4:0]  e_id;
        logic [3:0]  e_al;
        logic [31:0] e_res;
        logic        e_sc;
        logic [3:0]  e_sal;
        logic        e_rb, e_rv;
        logic [31:0] e_pc;
        logic        e_halt;
        logic [31:0] e_cnt;
    } vec_t;

    localparam logic [1:0] R = 2'd0, S = 2'd1, B = 2'd2, H = 2'd3;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        head_valid      = v.hv;
        head_ready      = v.hr;
        head_type       = v.ty;
        head_dest       = v.dst;
        head_alias      = v.al;
        head_value      = v.val;
        head_mispredict = v.mp;
        head_target_pc  = v.tgt;
        store_done      = v.sd;
        #1;
        chk({tag, ".pop"}, 32'(commit_pop), 32'(v.e_pop));
        @(posedge clk);
        #1;
        chk({tag, ".rfv"}, 32'(rf_result_valid), 32'(v.e_rfv));
        chk({tag, ".rid"}, 32'(rf_reg_id), 32'(v.e_id));
        chk({tag, ".ral"}, 32'(rf_alias), 32'(v.e_al));
        chk({tag, ".res"}, rf_result, v.e_res);
        chk({tag, ".sc"}, 32'(store_commit), 32'(v.e_sc));
        chk({tag, ".sal"}, 32'(store_alias), 32'(v.e_sal));
        chk({tag, ".rb"}, 32'(rollback), 32'(v.e_rb));
        chk({tag, ".rv"}, 32'(redirect_valid), 32'(v.e_rv));
        chk({tag, ".pc"}, redirect_pc, v.e_pc);
        chk({tag, ".halt"}, 32'(halted), 32'(v.e_halt));
        chk({tag, ".cnt"}, commit_count, v.e_cnt);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".pop"}, 32'(commit_pop), 32'd0);
        chk({tag, ".rfv"}, 32'(rf_result_valid), 32'd0);
        chk({tag, ".res"}, rf_result, 32'd0);
        chk({tag, ".sc"}, 32'(store_commit), 32'd0);
        chk({tag, ".sal"}, 32'(store_alias), 32'd0);
        chk({tag, ".rb"}, 32'(rollback), 32'd0);
        chk({tag, ".halt"}, 32'(halted), 32'd0);
        chk({tag, ".cnt"}, commit_count, 32'd0);
    endtask

    vec_t hv;

    initial begin
        //        hv hr ty dst al val mp tgt sd | pop rfv id al res sc sal rb rv pc halt cnt
        tbl[0]  = '{0,0,R,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0};
        tbl[1]  = '{1,1,R,5,1,1,0,0,0, 1,1,5,1,1,0,0,0,0,0,0,1};
        tbl[2]  = '{1,1,R,6,2,2,0,0,0, 1,1,6,2,2,0,0,0,0,0,0,2};
        tbl[3]  = '{1,1,R,7,3,3,0,0,0, 1,1,7,3,3,0,0,0,0,0,0,3};
        tbl[4]  = '{1,1,R,0,8,32'hDEAD,0,0,0, 1,0,0,8,32'hDEAD,0,0,0,0,0,0,4};
        tbl[5]  = '{1,0,R,9,9,32'h99,0,0,0, 0,0,0,8,32'hDEAD,0,0,0,0,0,0,4};
        tbl[6]  = '{1,1,S,0,4,32'h1234,0,0,0, 0,0,0,8,32'hDEAD,1,4,0,0,0,0,4};
        for (int i = 7; i <= 10; i++)
            tbl[i] = '{1,1,R,3,3,32'h77,0,0,0, 0,0,0,8,32'hDEAD,0,4,0,0,0,0,4};
        tbl[11] = '{0,0,R,0,0,0,0,0,1, 1,0,0,8,32'hDEAD,0,4,0,0,0,0,5};
        tbl[12] = '{0,0,R,0,0,0,0,0,1, 0,0,0,8,32'hDEAD,0,4,0,0,0,0,5};
        tbl[13] = '{1,1,B,1,9,32'h104,1,32'h200,0, 1,1,1,9,32'h104,0,4,0,0,0,0,6};
        tbl[14] = '{1,1,R,2,10,32'h55,0,0,0, 0,0,1,9,32'h104,0,4,1,1,32'h200,0,6};
        tbl[15] = '{1,1,R,2,10,32'h55,0,0,0, 0,0,1,9,32'h104,0,4,0,0,32'h200,0,6};
        tbl[16] = '{1,1,R,2,10,32'h55,0,0,0, 0,0,1,9,32'h104,0,4,0,0,32'h200,0,6};
        tbl[17] = '{1,1,R,2,10,32'h55,0,0,0, 1,1,2,10,32'h55,0,4,0,0,32'h200,0,7};
        tbl[18] = '{1,1,B,0,11,32'h300,0,32'h999,0, 1,0,0,11,32'h300,0,4,0,0,32'h200,0,8};
        tbl[19] = '{1,1,B,31,12,32'h400,0,32'h999,0, 1,1,31,12,32'h400,0,4,0,0,32'h200,0,9};

        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // rdy low: everything frozen, pulse on rf_result_valid held
        rdy = 1'b0;
        hv = '{1,1,R,4,13,32'h44,0,0,0, 0,1,31,12,32'h400,0,4,0,0,32'h200,0,9};
        for (int i = 0; i < 3; i++)
            apply(hv, $sformatf("stall%0d", i));
        rdy = 1'b1;
        hv = '{1,1,R,4,13,32'h44,0,0,0, 1,1,4,13,32'h44,0,4,0,0,32'h200,0,10};
        apply(hv, "resume");

        hv = '{1,1,H,0,14,0,0,0,0, 1,0,4,13,32'h44,0,4,0,0,32'h200,1,11};
        apply(hv, "halt");
        hv = '{1,1,R,6,15,32'h66,0,0,0, 0,0,4,13,32'h44,0,4,0,0,32'h200,1,11};
        apply(hv, "halted");

        // asynchronous reset mid-cycle out of HALT
        @(negedge clk);
        head_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("rst_halt");
        @(negedge clk);
        rst = 1'b0;

        hv = '{1,1,S,0,4,32'h5,0,0,0, 0,0,0,0,0,1,4,0,0,0,0,0};
        apply(hv, "st2");
        @(negedge clk);
        head_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_wait");
        @(negedge clk);
        rst = 1'b0;

        hv = '{0,0,R,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0,0,0};
        apply(hv, "post_rst_sd");
        hv = '{1,1,R,5,1,1,0,0,0, 1,1,5,1,1,0,0,0,0,0,0,1};
        apply(hv, "post_rst_reg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
